// File: rtl/m_mc_pkg.sv
// Shared definitions for the m_mc_proc multi-cycle core: opcodes, funct codes,
// FSM state encoding and the instruction classes the decoder produces.
package m_mc_pkg;

   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_LUI    = 5'b01101;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   localparam logic [6:0] F7_ADD = 7'b0000000;
   localparam logic [6:0] F7_SUB = 7'b0100000;
   localparam logic [6:0] F7_MUL = 7'b0000001;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT
   } state_t;

   typedef enum logic [2:0] {
      CL_NOP,
      CL_ALU,
      CL_LUI,
      CL_JAL,
      CL_LOAD,
      CL_STORE,
      CL_BRANCH
   } iclass_t;

endpackage

// File: rtl/m_mc_regfile.sv
// 32-entry register file for m_mc_proc: two async read ports, one write port.
// x0 always reads zero and ignores writes.
module m_mc_regfile #(
   parameter int XLEN = 32
) (
   input  logic            w_clk,
   input  logic            w_rst_n,
   input  logic [4:0]      w_rs1_idx,
   output logic [XLEN-1:0] w_rs1_data,
   input  logic [4:0]      w_rs2_idx,
   output logic [XLEN-1:0] w_rs2_data,
   input  logic            w_we,
   input  logic [4:0]      w_wr_idx,
   input  logic [XLEN-1:0] w_wr_data
);

   logic [XLEN-1:0] regs [32];

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else if (w_we && (w_wr_idx != 5'd0)) begin
         regs[w_wr_idx] <= w_wr_data;
      end
   end

   assign w_rs1_data = (w_rs1_idx == 5'd0) ? '0 : regs[w_rs1_idx];
   assign w_rs2_data = (w_rs2_idx == 5'd0) ? '0 : regs[w_rs2_idx];

endmodule

// File: rtl/m_mc_proc.sv
// Multi-cycle RV32I-subset core (ADD SUB ADDI LW SW BEQ BNE JAL LUI) with internal imem/dmem.
// Optional MUL support when M_MC_PROC_MUL_EN is defined.
//
// state    | meaning
// FETCH    | IR <= imem[pc]
// DECODE   | A/B <= rf[rs1]/rf[rs2]
// EXEC     | ALU / address / branch resolve (final state for branch and NOP)
// MEM      | LW read into MDR, SW write (final state for SW)
// WB       | rf write, pc advance (final state for ALU/LUI/JAL/LW)
// HALT     | absorbing, entered after writing HALT_REG
module m_mc_proc
   import m_mc_pkg::*;
#(
   parameter int          XLEN       = 32,
   parameter int          IMEM_DEPTH = 64,
   parameter int          DMEM_DEPTH = 64,
   parameter int unsigned RESET_PC   = 0,
   parameter int          HALT_REG   = 30
) (
   input  logic            w_clk,
   input  logic            w_rst_n,
   output logic [XLEN-1:0] w_pc,
   output logic            w_retire,
   output logic            w_wb_en,
   output logic [4:0]      w_wb_idx,
   output logic [XLEN-1:0] w_wb_data,
   output logic            w_halt
);

   localparam int         IMEM_AW  = $clog2(IMEM_DEPTH);
   localparam int         DMEM_AW  = $clog2(DMEM_DEPTH);
   localparam logic [4:0] HALT_IDX = 5'(HALT_REG);

   logic [31:0]     mem  [IMEM_DEPTH];
   logic [XLEN-1:0] dmem [DMEM_DEPTH];

   state_t          state;
   iclass_t         icls;
   logic [31:0]     ir;
   logic [XLEN-1:0] a_q, b_q, aluout, mdr;
   logic [XLEN-1:0] rs1_data, rs2_data;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [XLEN-1:0] alu_res, mem_addr, pc_plus4, ld_data, rf_wr_data;
   logic [4:0]      rd;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic            is_sub, br_taken;
`ifdef M_MC_PROC_MUL_EN
   logic            is_mul;
`endif

   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign funct7 = ir[31:25];

   assign imm_i = XLEN'($signed(ir[31:20]));
   assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
   assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
   assign imm_u = XLEN'($signed({ir[31:12], 12'h000}));
   assign imm_j = XLEN'($signed({ir[31], ir[19:12], ir[20], ir[30:21], 1'b0}));

   // Anything not recognised, including a malformed ir[1:0], decodes as a 3-cycle NOP.
   always_comb begin
      icls   = CL_NOP;
      is_sub = 1'b0;
`ifdef M_MC_PROC_MUL_EN
      is_mul = 1'b0;
`endif
      if (ir[1:0] == 2'b11) begin
         case (ir[6:2])
            OPC_OP: begin
               if (funct3 == F3_ADD) begin
                  if (funct7 == F7_ADD) begin
                     icls = CL_ALU;
                  end else if (funct7 == F7_SUB) begin
                     icls   = CL_ALU;
                     is_sub = 1'b1;
                  end
`ifdef M_MC_PROC_MUL_EN
                  else if (funct7 == F7_MUL) begin
                     icls   = CL_ALU;
                     is_mul = 1'b1;
                  end
`endif
               end
            end
            OPC_OPIMM:  if (funct3 == F3_ADD) icls = CL_ALU;
            OPC_LUI:    icls = CL_LUI;
            OPC_JAL:    icls = CL_JAL;
            OPC_LOAD:   if (funct3 == F3_LW) icls = CL_LOAD;
            OPC_STORE:  if (funct3 == F3_SW) icls = CL_STORE;
            OPC_BRANCH: if ((funct3 == F3_BEQ) || (funct3 == F3_BNE)) icls = CL_BRANCH;
            default:    icls = CL_NOP;
         endcase
      end
   end

   assign pc_plus4 = w_pc + XLEN'(4);
   assign br_taken = (a_q == b_q) ^ funct3[0];
   assign mem_addr = a_q + ((icls == CL_STORE) ? imm_s : imm_i);
   assign ld_data  = dmem[aluout[DMEM_AW+1:2]];

   // ir[5] separates OP (register operand) from OPIMM (immediate operand).
   always_comb begin
      alu_res = a_q + (ir[5] ? b_q : imm_i);
      if (icls == CL_JAL)      alu_res = pc_plus4;
      else if (icls == CL_LUI) alu_res = imm_u;
      else if (is_sub)         alu_res = a_q - b_q;
`ifdef M_MC_PROC_MUL_EN
      else if (is_mul)         alu_res = a_q * b_q;
`endif
   end

   assign rf_wr_data = (icls == CL_LOAD) ? mdr : aluout;

   m_mc_regfile #(.XLEN(XLEN)) u_rf (
      .w_clk      (w_clk),
      .w_rst_n    (w_rst_n),
      .w_rs1_idx  (ir[19:15]),
      .w_rs1_data (rs1_data),
      .w_rs2_idx  (ir[24:20]),
      .w_rs2_data (rs2_data),
      .w_we       (state == S_WB),
      .w_wr_idx   (rd),
      .w_wr_data  (rf_wr_data)
   );

   // Retire/writeback outputs are loaded on entry to the final state so they are valid there only.
   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state     <= S_FETCH;
         w_pc      <= XLEN'(RESET_PC);
         ir        <= '0;
         a_q       <= '0;
         b_q       <= '0;
         aluout    <= '0;
         mdr       <= '0;
         w_retire  <= 1'b0;
         w_wb_en   <= 1'b0;
         w_wb_idx  <= '0;
         w_wb_data <= '0;
         w_halt    <= 1'b0;
      end else begin
         w_retire  <= 1'b0;
         w_wb_en   <= 1'b0;
         w_wb_idx  <= '0;
         w_wb_data <= '0;
         case (state)
            S_FETCH: begin
               ir    <= mem[w_pc[IMEM_AW+1:2]];
               state <= S_DECODE;
            end
            S_DECODE: begin
               a_q      <= rs1_data;
               b_q      <= rs2_data;
               w_retire <= (icls == CL_BRANCH) || (icls == CL_NOP);
               state    <= S_EXEC;
            end
            S_EXEC: begin
               case (icls)
                  CL_BRANCH: begin
                     w_pc  <= br_taken ? (w_pc + imm_b) : pc_plus4;
                     state <= S_FETCH;
                  end
                  CL_LOAD, CL_STORE: begin
                     aluout   <= mem_addr;
                     w_retire <= (icls == CL_STORE);
                     state    <= S_MEM;
                  end
                  CL_ALU, CL_LUI, CL_JAL: begin
                     aluout    <= alu_res;
                     w_retire  <= 1'b1;
                     w_wb_en   <= (rd != 5'd0);
                     w_wb_idx  <= rd;
                     w_wb_data <= alu_res;
                     if (icls == CL_JAL) w_pc <= w_pc + imm_j;
                     state     <= S_WB;
                  end
                  default: begin
                     w_pc  <= pc_plus4;
                     state <= S_FETCH;
                  end
               endcase
            end
            S_MEM: begin
               if (icls == CL_LOAD) begin
                  mdr       <= ld_data;
                  w_retire  <= 1'b1;
                  w_wb_en   <= (rd != 5'd0);
                  w_wb_idx  <= rd;
                  w_wb_data <= ld_data;
                  state     <= S_WB;
               end else begin
                  w_pc  <= pc_plus4;
                  state <= S_FETCH;
               end
            end
            S_WB: begin
               if (rd == HALT_IDX) begin
                  w_halt <= 1'b1;
                  state  <= S_HALT;
               end else begin
                  if (icls != CL_JAL) w_pc <= pc_plus4;
                  state <= S_FETCH;
               end
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_FETCH;
         endcase
      end
   end

   // State is async-reset to FETCH, so a reset asserted during MEM cannot reach this write.
   always_ff @(posedge w_clk) begin
      if ((state == S_MEM) && (icls == CL_STORE))
         dmem[aluout[DMEM_AW+1:2]] <= b_q;
   end

endmodule

// File: tb/tb_m_mc_proc.sv
// Directed bench for m_mc_proc: table of small programs ending in a halt write,
// plus hand sequences for retire timing and reset during a store.
module tb_m_mc_proc;
   import m_mc_pkg::*;

   logic        w_clk = 1'b0;
   logic        w_rst_n = 1'b1;
   logic [31:0] w_pc;
   logic        w_retire;
   logic        w_wb_en;
   logic [4:0]  w_wb_idx;
   logic [31:0] w_wb_data;
   logic        w_halt;

   int checks = 0;
   int failures = 0;

   int          rt  [16];
   logic        wbe [16];
   logic [4:0]  wbi [16];
   logic [31:0] wbd [16];

   typedef struct packed {
      logic [7:0][31:0] prog;
      logic [4:0]       r0;
      logic [31:0]      v0;
      logic [4:0]       r1;
      logic [31:0]      v1;
      logic [31:0]      pc;
      logic [7:0]       nret;
      logic [7:0]       ncyc;
      logic             wb0;
   } vec_t;

   vec_t vecs [9];

   m_mc_proc dut (
      .w_clk     (w_clk),
      .w_rst_n   (w_rst_n),
      .w_pc      (w_pc),
      .w_retire  (w_retire),
      .w_wb_en   (w_wb_en),
      .w_wb_idx  (w_wb_idx),
      .w_wb_data (w_wb_data),
      .w_halt    (w_halt)
   );

   always #5 w_clk = ~w_clk;

   function automatic logic [31:0] f_addi(int rd, int rs1, int imm);
      return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
   endfunction

   function automatic logic [31:0] f_r(int f7, int rd, int rs1, int rs2);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
   endfunction

   function automatic logic [31:0] f_lw(int rd, int rs1, int imm);
      return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
   endfunction

   function automatic logic [31:0] f_sw(int rs2, int rs1, int imm);
      logic [11:0] im;
      im = 12'(imm);
      return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] f_br(int f3, int rs1, int rs2, int imm);
      logic [12:0] im;
      im = 13'(imm);
      return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] f_jal(int rd, int imm);
      logic [20:0] im;
      im = 21'(imm);
      return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'b1101111};
   endfunction

   function automatic logic [31:0] f_lui(int rd, int imm20);
      return {20'(imm20), 5'(rd), 7'b0110111};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
      end
   endtask

   task automatic load_prog(input vec_t v);
      for (int i = 0; i < 64; i++) dut.mem[i] = 32'h0;
      for (int i = 0; i < 8; i++) dut.mem[i] = v.prog[i];
   endtask

   task automatic run_vec(input vec_t v, input int id);
      int          cyc;
      int          nret;
      int          extra;
      bit          done;
      logic [31:0] pc_h;
      w_rst_n = 1'b0;
      load_prog(v);
      for (int i = 0; i < 16; i++) begin
         rt[i] = 0; wbe[i] = 1'b0; wbi[i] = '0; wbd[i] = '0;
      end
      repeat (2) @(negedge w_clk);
      w_rst_n = 1'b1;
      cyc = 0; nret = 0; done = 1'b0;
      while (!done && cyc < 200) begin
         @(posedge w_clk); #1;
         cyc++;
         if (w_retire) begin
            if (nret < 16) begin
               rt[nret] = cyc; wbe[nret] = w_wb_en; wbi[nret] = w_wb_idx; wbd[nret] = w_wb_data;
            end
            nret++;
         end
         if (w_halt) done = 1'b1;
      end
      chk($sformatf("v%0d_halt_reached", id), 32'(done), 32'd1);
      chk($sformatf("v%0d_cycles", id), 32'(cyc), 32'(v.ncyc));
      chk($sformatf("v%0d_retires", id), 32'(nret), 32'(v.nret));
      chk($sformatf("v%0d_first_wb_en", id), 32'(wbe[0]), 32'(v.wb0));
      chk($sformatf("v%0d_pc", id), w_pc, v.pc);
      chk($sformatf("v%0d_x%0d", id, v.r0), dut.u_rf.regs[v.r0], v.v0);
      chk($sformatf("v%0d_x%0d", id, v.r1), dut.u_rf.regs[v.r1], v.v1);
      pc_h = w_pc;
      extra = 0;
      repeat (5) begin
         @(posedge w_clk); #1;
         if (w_retire) extra++;
      end
      chk($sformatf("v%0d_halt_no_retire", id), 32'(extra), 32'd0);
      chk($sformatf("v%0d_halt_pc_frozen", id), w_pc, pc_h);
      chk($sformatf("v%0d_halt_sticky", id), 32'(w_halt), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t t;
      logic [31:0] hlt;
      hlt = f_addi(30, 0, 1);

      t = '0;
      t.prog[0] = f_addi(1, 0, 5); t.prog[1] = f_addi(2, 1, -7); t.prog[2] = hlt;
      t.r0 = 5'd2; t.v0 = 32'hFFFF_FFFE; t.r1 = 5'd1; t.v1 = 32'd5;
      t.pc = 32'h8; t.nret = 8'd3; t.ncyc = 8'd12; t.wb0 = 1'b1;
      vecs[0] = t;

      t = '0;
      t.prog[0] = f_addi(1, 0, 9); t.prog[1] = f_sw(1, 0, 8); t.prog[2] = f_lw(3, 0, 8);
      t.prog[3] = hlt;
      t.r0 = 5'd3; t.v0 = 32'd9; t.r1 = 5'd1; t.v1 = 32'd9;
      t.pc = 32'hC; t.nret = 8'd4; t.ncyc = 8'd17; t.wb0 = 1'b1;
      vecs[1] = t;

      t = '0;
      t.prog[0] = f_addi(1, 0, 1); t.prog[1] = f_br(1, 1, 0, 8); t.prog[2] = f_addi(4, 0, 1);
      t.prog[3] = f_addi(5, 0, 2); t.prog[4] = hlt;
      t.r0 = 5'd5; t.v0 = 32'd2; t.r1 = 5'd4; t.v1 = 32'd0;
      t.pc = 32'h10; t.nret = 8'd4; t.ncyc = 8'd15; t.wb0 = 1'b1;
      vecs[2] = t;

      t = '0;
      t.prog[0] = f_addi(1, 0, 3); t.prog[1] = f_addi(2, 0, 10); t.prog[2] = f_r(32, 3, 1, 2);
      t.prog[3] = f_r(0, 4, 1, 2); t.prog[4] = hlt;
      t.r0 = 5'd3; t.v0 = 32'hFFFF_FFF9; t.r1 = 5'd4; t.v1 = 32'd13;
      t.pc = 32'h10; t.nret = 8'd5; t.ncyc = 8'd20; t.wb0 = 1'b1;
      vecs[3] = t;

      t = '0;
      t.prog[0] = f_lui(7, 32'h12345); t.prog[1] = f_addi(7, 7, 32'h678); t.prog[2] = f_br(0, 0, 0, 8);
      t.prog[3] = f_addi(8, 0, 1); t.prog[4] = hlt;
      t.r0 = 5'd7; t.v0 = 32'h1234_5678; t.r1 = 5'd8; t.v1 = 32'd0;
      t.pc = 32'h10; t.nret = 8'd4; t.ncyc = 8'd15; t.wb0 = 1'b1;
      vecs[4] = t;

      t = '0;
      t.prog[0] = f_addi(0, 0, 5); t.prog[1] = 32'hFFFF_FFFF; t.prog[2] = f_addi(9, 0, 1);
      t.prog[3] = hlt;
      t.r0 = 5'd9; t.v0 = 32'd1; t.r1 = 5'd0; t.v1 = 32'd0;
      t.pc = 32'hC; t.nret = 8'd4; t.ncyc = 8'd15; t.wb0 = 1'b0;
      vecs[5] = t;

      t = '0;
      t.prog[0] = f_addi(1, 0, 32'h55); t.prog[1] = f_sw(1, 0, 32'h108); t.prog[2] = f_lw(3, 0, 8);
      t.prog[3] = hlt;
      t.r0 = 5'd3; t.v0 = 32'h55; t.r1 = 5'd1; t.v1 = 32'h55;
      t.pc = 32'hC; t.nret = 8'd4; t.ncyc = 8'd17; t.wb0 = 1'b1;
      vecs[6] = t;

      t = '0;
      t.prog[4] = f_jal(6, 12); t.prog[5] = f_addi(31, 0, 1); t.prog[6] = f_addi(31, 0, 2);
      t.prog[7] = f_addi(30, 0, 7);
      t.r0 = 5'd6; t.v0 = 32'h14; t.r1 = 5'd30; t.v1 = 32'd7;
      t.pc = 32'h1C; t.nret = 8'd6; t.ncyc = 8'd20; t.wb0 = 1'b0;
      vecs[7] = t;

      t = '0;
      t.prog[0] = f_addi(1, 0, 6); t.prog[1] = f_addi(2, 0, 7); t.prog[2] = f_r(1, 3, 1, 2);
      t.prog[3] = hlt;
      t.r1 = 5'd2; t.v1 = 32'd7; t.r0 = 5'd3;
      t.pc = 32'hC; t.nret = 8'd4; t.wb0 = 1'b1;
`ifdef M_MC_PROC_MUL_EN
      t.v0 = 32'd42; t.ncyc = 8'd16;
`else
      t.v0 = 32'd0;  t.ncyc = 8'd15;
`endif
      vecs[8] = t;

      #1 w_rst_n = 1'b0;
      #2;
      chk("reset_pc", w_pc, 32'h0);
      chk("reset_outputs", {27'd0, w_retire, w_wb_en, w_halt, 2'b00}, 32'd0);
      chk("reset_wb", {w_wb_data[26:0], w_wb_idx}, 32'd0);
      chk("reset_state", 32'(dut.state), 32'(S_FETCH));

      for (int k = 0; k < 9; k++) begin
         run_vec(vecs[k], k);
         case (k)
            0: begin
               chk("t1_retire_cycle_a", 32'(rt[0]), 32'd3);
               chk("t1_retire_cycle_b", 32'(rt[1]), 32'd7);
               chk("t1_wb_data_a", wbd[0], 32'd5);
               chk("t1_wb_idx_b", 32'(wbi[1]), 32'd2);
               chk("t1_wb_data_b", wbd[1], 32'hFFFF_FFFE);
            end
            1: begin
               chk("t2_sw_retire_cycle", 32'(rt[1]), 32'd7);
               chk("t2_lw_retire_cycle", 32'(rt[2]), 32'd12);
               chk("t2_lw_wb_data", wbd[2], 32'd9);
            end
            2: chk("t3_branch_retire_cycle", 32'(rt[1]), 32'd6);
            7: begin
               chk("t4_jal_wb_idx", 32'(wbi[4]), 32'd6);
               chk("t4_jal_wb_data", wbd[4], 32'h14);
            end
            default: ;
         endcase
      end

      // Reset asserted while a store sits in MEM must not write dmem.
      w_rst_n = 1'b0;
      t = '0;
      t.prog[0] = f_addi(1, 0, 32'h33); t.prog[1] = f_sw(1, 0, 32'h20); t.prog[2] = hlt;
      load_prog(t);
      dut.dmem[8] = 32'h0000_DEAD;
      repeat (2) @(negedge w_clk);
      w_rst_n = 1'b1;
      repeat (7) @(posedge w_clk);
      #1;
      chk("t5_state_mem", 32'(dut.state), 32'(S_MEM));
      chk("t5_sw_retire", 32'(w_retire), 32'd1);
      #2 w_rst_n = 1'b0;
      #1;
      chk("t5_abort_retire", 32'(w_retire), 32'd0);
      chk("t5_abort_pc", w_pc, 32'h0);
      repeat (2) @(posedge w_clk);
      #1;
      chk("t5_dmem_unchanged", dut.dmem[8], 32'h0000_DEAD);
      chk("t5_rf_cleared", dut.u_rf.regs[1], 32'd0);
      @(negedge w_clk);
      w_rst_n = 1'b1;
      #1;
      chk("t5_state_after", 32'(dut.state), 32'(S_FETCH));
      chk("t5_pc_after", w_pc, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
